// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that lets NUM_CH requesters share one memory port, with one read in flight.
// Define MEM_BUS_ARB_TIMEOUT_EN to add a read-response timeout and the ch_rsp_err output.
module mem_bus_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_req_vld,
    output logic [NUM_CH-1:0]          ch_req_rdy,
    input  logic [2*NUM_CH-1:0]        ch_req_op,
    input  logic [ADDR_W*NUM_CH-1:0]   ch_req_addr,
    input  logic [DATA_W*NUM_CH-1:0]   ch_req_data,
    output logic [NUM_CH-1:0]          ch_rsp_vld,
    output logic [DATA_W-1:0]          ch_rsp_data,
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    output logic                       ch_rsp_err,
`endif
    output logic [1:0]                 mem_req_op,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [DATA_W-1:0]          mem_req_data,
    input  logic                       mem_rsp_vld,
    input  logic [DATA_W-1:0]          mem_rsp_data
);

    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SCAN_W = PTR_W + 1;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    owner;
    logic [PTR_W-1:0]    winner;
    logic [PTR_W-1:0]    next_ptr;
    logic [SCAN_W-1:0]   scan_idx;
    logic                found;
    op_t                 win_op;
    logic                win_is_mem;
    logic [NUM_CH-1:0]   grant;
    logic                timeout_hit;

    // Scan from the round-robin pointer upward with wrap; the first valid channel wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = {1'b0, rr_ptr} + SCAN_W'(k);
            if (scan_idx >= SCAN_W'(NUM_CH)) begin
                scan_idx = scan_idx - SCAN_W'(NUM_CH);
            end
            if (!found && ch_req_vld[scan_idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[PTR_W-1:0];
            end
        end
    end

    assign win_op     = op_t'(ch_req_op[2*winner +: 2]);
    assign win_is_mem = (win_op == OP_READ) || (win_op == OP_WRITE);
    assign next_ptr   = (winner == PTR_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        state_d = state_q;
        grant   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant[winner] = 1'b1;
                    if (win_is_mem) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE:    state_d = (mem_req_op == OP_READ) ? WAIT_RSP : IDLE;
            WAIT_RSP: if (mem_rsp_vld || timeout_hit) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Accept is combinational, so it must also be forced low while reset is held.
    assign ch_req_rdy = rst_n ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            owner        <= '0;
            mem_req_op   <= OP_NOP;
            mem_req_addr <= '0;
            mem_req_data <= '0;
            ch_rsp_vld   <= '0;
            ch_rsp_data  <= '0;
        end else begin
            // NOTE: non-blocking assignments for all registered state; later ones override the pulse defaults.
            mem_req_op <= OP_NOP;
            ch_rsp_vld <= '0;
            if (state_q == IDLE && found) begin
                rr_ptr <= next_ptr;
                if (win_is_mem) begin
                    mem_req_op   <= win_op;
                    mem_req_addr <= ch_req_addr[ADDR_W*winner +: ADDR_W];
                    mem_req_data <= ch_req_data[DATA_W*winner +: DATA_W];
                    owner        <= winner;
                end
            end
            if (state_q == WAIT_RSP) begin
                if (mem_rsp_vld) begin
                    ch_rsp_vld[owner] <= 1'b1;
                    ch_rsp_data       <= mem_rsp_data;
                end else if (timeout_hit) begin
                    ch_rsp_vld[owner] <= 1'b1;
                    ch_rsp_data       <= '0;
                end
            end
        end
    end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam int TIMEOUT = 16;

    logic [4:0] wait_cnt;

    // Fires in the last waiting cycle so the error pulse lands TIMEOUT cycles after entry.
    assign timeout_hit = (state_q == WAIT_RSP) && !mem_rsp_vld && (wait_cnt == 5'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            ch_rsp_err <= 1'b0;
        end else begin
            wait_cnt   <= (state_q == WAIT_RSP) ? wait_cnt + 5'd1 : 5'd0;
            ch_rsp_err <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level round-robin model.
module tb_mem_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      ch_req_vld;
    logic [N-1:0]      ch_req_rdy;
    logic [2*N-1:0]    ch_req_op;
    logic [AW*N-1:0]   ch_req_addr;
    logic [DW*N-1:0]   ch_req_data;
    logic [N-1:0]      ch_rsp_vld;
    logic [DW-1:0]     ch_rsp_data;
    logic [1:0]        mem_req_op;
    logic [AW-1:0]     mem_req_addr;
    logic [DW-1:0]     mem_req_data;
    logic              mem_rsp_vld;
    logic [DW-1:0]     mem_rsp_data;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    logic              ch_rsp_err;
`endif

    mem_bus_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_req_vld   (ch_req_vld),
        .ch_req_rdy   (ch_req_rdy),
        .ch_req_op    (ch_req_op),
        .ch_req_addr  (ch_req_addr),
        .ch_req_data  (ch_req_data),
        .ch_rsp_vld   (ch_rsp_vld),
        .ch_rsp_data  (ch_rsp_data),
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        .ch_rsp_err   (ch_rsp_err),
`endif
        .mem_req_op   (mem_req_op),
        .mem_req_addr (mem_req_addr),
        .mem_req_data (mem_req_data),
        .mem_rsp_vld  (mem_rsp_vld),
        .mem_rsp_data (mem_rsp_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: outstanding request per channel, RR pointer, and the response expected next idle cycle.
    bit            pend_v[N];
    logic [1:0]    pend_op[N];
    logic [AW-1:0] pend_addr[N];
    logic [DW-1:0] pend_data[N];
    int            ptr;
    bit            rsp_exp;
    int            rsp_ch;
    logic [DW-1:0] rsp_dat;
    bit            exp_err;

    int            w;
    logic [1:0]    op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int p);
        for (int k = 0; k < N; k++) begin
            if (pend_v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_pend();
        for (int c = 0; c < N; c++) begin
            pend_v[c]    = 1'b0;
            pend_op[c]   = 2'd0;
            pend_addr[c] = '0;
            pend_data[c] = '0;
        end
    endtask

    task automatic set_pend(input int c, input logic [1:0] o, input logic [AW-1:0] ad, input logic [DW-1:0] da);
        pend_v[c]    = 1'b1;
        pend_op[c]   = o;
        pend_addr[c] = ad;
        pend_data[c] = da;
    endtask

    task automatic drive_reqs();
        for (int c = 0; c < N; c++) begin
            ch_req_vld[c]            = pend_v[c];
            ch_req_op[2*c +: 2]      = pend_op[c];
            ch_req_addr[AW*c +: AW]  = pend_addr[c];
            ch_req_data[DW*c +: DW]  = pend_data[c];
        end
    endtask

    task automatic add_random();
        int r;
        for (int c = 0; c < N; c++) begin
            if (!pend_v[c] && $urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 9);
                set_pend(c, (r < 4) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd0 : 2'd3,
                         AW'($urandom), DW'($urandom));
            end
        end
    endtask

    // One cycle with the arbiter idle: predicts the grant and any response pulse due now.
    task automatic idle_cycle(input bit force_rsp, output int wo, output logic [1:0] oo,
                              output logic [AW-1:0] ao, output logic [DW-1:0] dout);
        drive_reqs();
        mem_rsp_vld  = force_rsp || ($urandom_range(0, 3) == 0);
        mem_rsp_data = DW'($urandom);
        @(negedge clk);
        wo = pick(ptr);
        check("rdy_idle", ch_req_rdy, (wo < 0) ? 0 : (1 << wo));
        check("rsp_vld_idle", ch_rsp_vld, rsp_exp ? (1 << rsp_ch) : 0);
        if (rsp_exp) check("rsp_data", ch_rsp_data, rsp_dat);
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        check("rsp_err", ch_rsp_err, exp_err);
`endif
        check("mem_op_idle", mem_req_op, 0);
        rsp_exp = 1'b0;
        exp_err = 1'b0;
        oo = 2'd0;
        ao = '0;
        dout = '0;
        if (wo >= 0) begin
            oo = pend_op[wo];
            ao = pend_addr[wo];
            dout = pend_data[wo];
            pend_v[wo] = 1'b0;
            ptr = (wo + 1) % N;
        end
        @(posedge clk);
        #1;
        mem_rsp_vld = 1'b0;
    endtask

    task automatic issue_phase(input logic [1:0] o, input logic [AW-1:0] ad, input logic [DW-1:0] da);
        drive_reqs();
        mem_rsp_vld = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        check("mem_op_issue", mem_req_op, o);
        check("mem_addr_issue", mem_req_addr, ad);
        check("mem_data_issue", mem_req_data, da);
        check("rdy_issue", ch_req_rdy, 0);
        check("rsp_vld_issue", ch_rsp_vld, 0);
        @(posedge clk);
        #1;
        mem_rsp_vld = 1'b0;
    endtask

    // mode 0: just wait; 1: memory answers after lat quiet cycles; 2: expect a timeout pulse.
    task automatic wait_phase(input int lat, input int mode, input int ch, input logic [DW-1:0] rdata);
        for (int i = 0; i < lat; i++) begin
            drive_reqs();
            @(negedge clk);
            check("rdy_wait", ch_req_rdy, 0);
            check("rsp_vld_wait", ch_rsp_vld, 0);
`ifdef MEM_BUS_ARB_TIMEOUT_EN
            check("rsp_err_wait", ch_rsp_err, 0);
`endif
            @(posedge clk);
            #1;
        end
        if (mode == 1) begin
            drive_reqs();
            mem_rsp_vld  = 1'b1;
            mem_rsp_data = rdata;
            @(negedge clk);
            check("rdy_rsp", ch_req_rdy, 0);
            check("rsp_vld_early", ch_rsp_vld, 0);
            @(posedge clk);
            #1;
            mem_rsp_vld = 1'b0;
            rsp_exp = 1'b1;
            rsp_ch  = ch;
            rsp_dat = rdata;
            exp_err = 1'b0;
        end else if (mode == 2) begin
            rsp_exp = 1'b1;
            rsp_ch  = ch;
            rsp_dat = '0;
            exp_err = 1'b1;
        end
    endtask

    task automatic run_txn(input bit refill);
        int            wl;
        logic [1:0]    ol;
        logic [AW-1:0] al;
        logic [DW-1:0] dl;
        idle_cycle(1'b0, wl, ol, al, dl);
        if (wl >= 0 && refill) begin
            set_pend(wl, ol, al, DW'($urandom));
        end
        if (wl >= 0 && (ol == 2'd1 || ol == 2'd2)) issue_phase(ol, al, dl);
        if (wl >= 0 && ol == 2'd1) wait_phase($urandom_range(0, 4), 1, wl, DW'($urandom));
    endtask

    task automatic do_reset();
        clear_pend();
        drive_reqs();
        mem_rsp_vld = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ptr = 0;
        rsp_exp = 1'b0;
        exp_err = 1'b0;
    endtask

    initial begin
        clear_pend();
        drive_reqs();
        mem_rsp_vld  = 1'b0;
        mem_rsp_data = '0;
        ptr = 0;
        rsp_exp = 1'b0;
        exp_err = 1'b0;
        rsp_ch = 0;
        rsp_dat = '0;

        // Reset held 3 cycles; accept must stay low even with every channel requesting.
        rst_n = 1'b0;
        ch_req_vld = '1;
        repeat (3) begin
            @(negedge clk);
            check("rdy_in_reset", ch_req_rdy, 0);
            check("mem_op_in_reset", mem_req_op, 0);
            check("rsp_vld_in_reset", ch_rsp_vld, 0);
        end
        ch_req_vld = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            idle_cycle(1'b0, w, op, a, d);
            check("mem_addr_idle", mem_req_addr, 0);
            check("mem_data_idle", mem_req_data, 0);
            check("rsp_data_idle", ch_rsp_data, 0);
        end

        // Single write on ch1.
        set_pend(1, 2'd2, 6'h2A, 8'h5C);
        run_txn(1'b0);

        // Read on ch2, memory answers 3 cycles after issue.
        set_pend(2, 2'd1, 6'h10, 8'h00);
        idle_cycle(1'b0, w, op, a, d);
        issue_phase(op, a, d);
        wait_phase(2, 1, 2, 8'hA7);
        idle_cycle(1'b0, w, op, a, d);

        // Contention: ch3 write raised while ch0 read is outstanding.
        set_pend(0, 2'd1, 6'h05, 8'h00);
        idle_cycle(1'b0, w, op, a, d);
        issue_phase(op, a, d);
        set_pend(3, 2'd2, 6'h33, 8'h9E);
        wait_phase(3, 1, 0, 8'h3C);
        idle_cycle(1'b0, w, op, a, d);
        issue_phase(op, a, d);

        // Round robin from reset with all four channels writing continuously.
        do_reset();
        for (int c = 0; c < N; c++) set_pend(c, 2'd2, AW'(c + 8), DW'($urandom));
        repeat (8) run_txn(1'b1);
        clear_pend();

        // Reserved and NOP ops are accepted and dropped.
        set_pend(1, 2'd3, 6'h01, 8'h11);
        set_pend(2, 2'd0, 6'h02, 8'h22);
        repeat (3) run_txn(1'b0);

        // Reset in WAIT_RSP aborts the read; a late response is ignored.
        set_pend(0, 2'd1, 6'h3F, 8'h00);
        idle_cycle(1'b0, w, op, a, d);
        issue_phase(op, a, d);
        wait_phase(2, 0, 0, 8'h00);
        set_pend(1, 2'd2, 6'h21, 8'h44);
        drive_reqs();
        rst_n = 1'b0;
        #2;
        check("rdy_mid_reset", ch_req_rdy, 0);
        check("mem_op_mid_reset", mem_req_op, 0);
        check("mem_addr_mid_reset", mem_req_addr, 0);
        check("mem_data_mid_reset", mem_req_data, 0);
        check("rsp_vld_mid_reset", ch_rsp_vld, 0);
        check("rsp_data_mid_reset", ch_rsp_data, 0);
        clear_pend();
        drive_reqs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ptr = 0;
        rsp_exp = 1'b0;
        exp_err = 1'b0;
        idle_cycle(1'b1, w, op, a, d);
        idle_cycle(1'b0, w, op, a, d);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
        // Read with no memory answer: error pulse 16 cycles after entering WAIT_RSP.
        set_pend(1, 2'd1, 6'h0C, 8'h00);
        idle_cycle(1'b0, w, op, a, d);
        issue_phase(op, a, d);
        wait_phase(16, 2, 1, 8'h00);
        idle_cycle(1'b1, w, op, a, d);
        idle_cycle(1'b0, w, op, a, d);
`endif

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            add_random();
            run_txn(1'b0);
        end
        clear_pend();
        repeat (2) idle_cycle(1'b0, w, op, a, d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised successor to the single-requester memory bus: N requester channels share one memory port.
- Per channel: valid/ready request handshake, with configurable address and data widths.
- Round-robin arbitration, one outstanding read at a time; the read response is routed back to the originating channel.
- Sits between test-bench/cache clients and the memory model, on the same clk.

Parameters:
NUM_CH, 4, number of requester channels (2..8)
ADDR_W, 6, address width in bits
DATA_W, 8, data width in bits

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
ch_req_vld  input  NUM_CH  per-channel request valid
ch_req_rdy  output  NUM_CH  per-channel request accepted (one-hot or zero)
ch_req_op  input  2*NUM_CH  per-channel op; channel i at [2i+1:2i]; 0=NOP, 1=READ, 2=WRITE, 3=reserved
ch_req_addr  input  ADDR_W*NUM_CH  per-channel address, packed the same way
ch_req_data  input  DATA_W*NUM_CH  per-channel write data
ch_rsp_vld  output  NUM_CH  one-cycle read-response pulse to the owning channel
ch_rsp_data  output  DATA_W  read data, valid where ch_rsp_vld is set
mem_req_op  output  2  memory op, one-cycle pulse, NOP otherwise
mem_req_addr  output  ADDR_W  memory address
mem_req_data  output  DATA_W  memory write data
mem_rsp_vld  input  1  memory read response valid
mem_rsp_data  input  DATA_W  memory read data

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE and the RR pointer to 0.
  - mem_req_op=NOP; mem_req_addr and mem_req_data = 0.
  - ch_rsp_vld=0, ch_rsp_data=0, owner=0.
  - ch_req_rdy=0 combinationally while in reset.
- States: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - Winner = first channel with ch_req_vld=1, searching from the RR pointer upward with wrap-around.
  - ch_req_rdy[winner]=1 combinationally in that same cycle; all other bits stay 0.
  - On that edge, capture op/addr/data into the mem_req_* registers, record owner=winner, set RR pointer=winner+1 mod NUM_CH, and go to ISSUE.
  - With no valid request, stay in IDLE and keep the pointer unchanged.
- Reserved op 3 or NOP on a valid channel: accepted (rdy pulses), dropped, no memory op, pointer advances, stay in IDLE.
- ISSUE:
  - The mem_req_* registers hold the request for exactly one cycle.
  - At the end of the cycle, mem_req_op returns to NOP; addr and data hold their last value.
  - WRITE goes back to IDLE. READ goes to WAIT_RSP.
- WAIT_RSP:
  - ch_req_rdy stays all 0.
  - On mem_rsp_vld=1: register ch_rsp_data=mem_rsp_data and pulse ch_rsp_vld[owner] for one cycle on the next edge, then go to IDLE.
  - In that IDLE cycle arbitration runs normally, so a new grant may coincide with the response pulse.
- mem_rsp_vld in IDLE or ISSUE is spurious: ignored, no response generated.
- Latency:
  - Grant to mem_req_op pulse: 1 cycle.
  - mem_rsp_vld to ch_rsp_vld: 1 cycle.
  - Back-to-back writes: one accepted every 2 cycles.
- Requesters must hold vld/op/addr/data stable until rdy. The arbiter does not check this.
- Fairness: a continuously requesting channel waits at most NUM_CH-1 grants.
- Mid-operation reset (including in WAIT_RSP) aborts the transaction. A later mem_rsp_vld is ignored.

Optional Feature:
- Macro MEM_BUS_ARB_TIMEOUT_EN.
- Defined:
  - Adds localparam TIMEOUT=16, a 5-bit wait counter and output port ch_rsp_err (1 bit).
  - The counter clears on entry to WAIT_RSP and increments each cycle there.
  - If it reaches TIMEOUT with no mem_rsp_vld: pulse ch_rsp_vld[owner] with ch_rsp_err=1 and ch_rsp_data=0, then go to IDLE.
  - ch_rsp_err=0 on normal responses; it resets to 0.
- Not defined: no port, no counter; WAIT_RSP waits indefinitely.

Test Plan:
- Reset then idle: rst_n low 3 cycles, all ch_req_vld=0 -> all outputs 0, mem_req_op=NOP for 10 cycles.
- Single write: ch1 WRITE addr=0x2A data=0x5C -> ch_req_rdy=4'b0010 for 1 cycle; next cycle mem_req_op=2, addr=0x2A, data=0x5C for exactly 1 cycle; no ch_rsp_vld.
- Read with latency: ch2 READ addr=0x10, memory answers 3 cycles after issue with 0xA7 -> one cycle later ch_rsp_vld=4'b0100, ch_rsp_data=0xA7; ch_req_rdy=0 throughout WAIT_RSP.
- Round-robin: all four channels hold WRITE continuously from reset -> grants in order ch0,ch1,ch2,ch3,ch0, one every 2 cycles.
- Contention during read: ch0 READ pending, ch3 raises WRITE -> ch3 not granted until the cycle after mem_rsp_vld; ch0 response pulse and ch3 grant then happen the same cycle.
- With MEM_BUS_ARB_TIMEOUT_EN: ch1 READ, mem_rsp_vld never asserted -> 16 cycles after entering WAIT_RSP, ch_rsp_vld=4'b0010 with ch_rsp_err=1, then arbiter returns to IDLE; a late mem_rsp_vld is ignored.
